// File: rtl/ctx_pkg.sv
// ctx_pkg: shared state encoding, beat sizing and header field layout for the context loader.
package ctx_pkg;
    typedef enum logic [1:0] {IDLE, RECV, WRITE, LAUNCH} state_t;
    localparam int DEF_WIDTH = 120;
    localparam int HDR_PE_LSB = 0;
    localparam int HDR_BASE_LSB = 8;
    localparam int HDR_CNT_LSB = 16;
    localparam int HDR_GO_BIT = 31;
    function automatic int beats_for(input int width);
        return (width + 32) / 32;
    endfunction
    localparam int BEATS = beats_for(DEF_WIDTH);
endpackage

// File: rtl/context_loader_if.sv
// context_loader_if: host word stream plus PE context-write bus of the context loader.
interface context_loader_if import ctx_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NUM_PE = 16,
    parameter int AW = 4
);
    logic [31:0] in_data;
    logic in_valid;
    logic in_ready;
    logic [WIDTH:0] ctx_data;
    logic [AW-1:0] ctx_addr;
    logic [NUM_PE-1:0] pe_sel;
    logic wr_en;
    logic start;
    logic busy;
    logic err;
    modport master (
        output in_data, in_valid,
        input in_ready, ctx_data, ctx_addr, pe_sel, wr_en, start, busy, err
    );
    modport slave (
        input in_data, in_valid,
        output in_ready, ctx_data, ctx_addr, pe_sel, wr_en, start, busy, err
    );
endinterface

// File: rtl/ctx_assembler.sv
// ctx_assembler: packs consecutive 32-bit beats into one WIDTH+1-bit context word.
module ctx_assembler import ctx_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH
) (
    input logic CLK,
    input logic RST_N,
    input logic beat_i,
    input logic clr_i,
    input logic [31:0] data_i,
    output logic [WIDTH:0] word_o,
    output logic last_o
);
    localparam int NB = beats_for(WIDTH);
    localparam int CW = $clog2(NB + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic [WIDTH:0] word_q, word_d;
    // word_o includes the beat being accepted so the caller can register the final word on the last beat
    always_comb begin
        last_o = beat_i && cnt_q == CW'(NB - 1);
        cnt_d = clr_i ? '0 : !beat_i ? cnt_q : last_o ? '0 : cnt_q + 1'b1;
        word_d = word_q;
        for (int b = 0; b <= WIDTH; b++)
            word_d[b] = (beat_i && cnt_q == CW'(b / 32)) ? data_i[b % 32] : word_q[b];
    end
    assign word_o = word_d;
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q <= '0;
            word_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            word_q <= word_d;
        end
    end
endmodule

// File: rtl/context_loader.sv
// context_loader: decodes framed host words into per-PE context-cache writes and a launch pulse.
module context_loader import ctx_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NUM_PE = 16,
    parameter int DEPTH = 16,
    parameter int AW = 4
) (
    input logic CLK,
    input logic RST_N,
    context_loader_if.slave bus
);
    state_t state_q;
    logic [7:0] pe_q, base_q, cnt_q, idx_q;
    logic go_q, bad_q;
    logic in_ready_q, wr_en_q, start_q, busy_q, err_q;
    logic [NUM_PE-1:0] pe_sel_q;
    logic [AW-1:0] ctx_addr_q;
    logic [WIDTH:0] ctx_data_q, word;
    logic hs, beat, last, h_go, h_bad;
    logic [7:0] h_pe, h_base, h_cnt;
    assign hs = bus.in_valid && in_ready_q;
    assign beat = hs && state_q == RECV;
    assign h_pe = bus.in_data[HDR_PE_LSB +: 8];
    assign h_base = bus.in_data[HDR_BASE_LSB +: 8];
    assign h_cnt = bus.in_data[HDR_CNT_LSB +: 8];
    assign h_go = bus.in_data[HDR_GO_BIT];
    assign h_bad = 32'(h_pe) >= NUM_PE || 32'(h_base) + 32'(h_cnt) > DEPTH;
    ctx_assembler #(.WIDTH(WIDTH)) u_asm (
        .CLK(CLK),
        .RST_N(RST_N),
        .beat_i(beat),
        .clr_i(state_q == IDLE),
        .data_i(bus.in_data),
        .word_o(word),
        .last_o(last)
    );
    // bad frames walk the same states so their payload is drained; only the write strobe is suppressed
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            pe_q <= '0;
            base_q <= '0;
            cnt_q <= '0;
            idx_q <= '0;
            go_q <= 1'b0;
            bad_q <= 1'b0;
            in_ready_q <= 1'b0;
            wr_en_q <= 1'b0;
            start_q <= 1'b0;
            busy_q <= 1'b0;
            err_q <= 1'b0;
            pe_sel_q <= '0;
            ctx_addr_q <= '0;
            ctx_data_q <= '0;
        end else begin
            start_q <= 1'b0;
            wr_en_q <= 1'b0;
            pe_sel_q <= '0;
            case (state_q)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (hs) begin
                        pe_q <= h_pe;
                        base_q <= h_base;
                        cnt_q <= h_cnt;
                        go_q <= h_go;
                        bad_q <= h_bad;
                        idx_q <= '0;
                        err_q <= err_q | h_bad;
                        if (h_cnt != 8'd0) begin
                            state_q <= RECV;
                            busy_q <= 1'b1;
                        end else if (h_go) begin
                            state_q <= LAUNCH;
                            busy_q <= 1'b1;
                            in_ready_q <= 1'b0;
                            start_q <= 1'b1;
                        end
                    end
                end
                RECV: begin
                    if (last) begin
                        state_q <= WRITE;
                        in_ready_q <= 1'b0;
                        wr_en_q <= !bad_q;
                        if (!bad_q) begin
                            pe_sel_q <= NUM_PE'(1) << pe_q;
                            ctx_addr_q <= AW'(base_q + idx_q);
                            ctx_data_q <= word;
                        end
                    end
                end
                WRITE: begin
                    idx_q <= idx_q + 8'd1;
                    if (idx_q + 8'd1 < cnt_q) begin
                        state_q <= RECV;
                        in_ready_q <= 1'b1;
                    end else if (go_q) begin
                        state_q <= LAUNCH;
                        start_q <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                        in_ready_q <= 1'b1;
                        busy_q <= 1'b0;
                    end
                end
                LAUNCH: begin
                    state_q <= IDLE;
                    in_ready_q <= 1'b1;
                    busy_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign bus.in_ready = in_ready_q;
    assign bus.wr_en = wr_en_q;
    assign bus.pe_sel = pe_sel_q;
    assign bus.ctx_addr = ctx_addr_q;
    assign bus.ctx_data = ctx_data_q;
    assign bus.start = start_q;
    assign bus.busy = busy_q;
    assign bus.err = err_q;
endmodule

// File: tb/tb_context_loader.sv
// tb_context_loader: randomized frames checked against a frame-level scoreboard of expected writes.
module tb_context_loader;
    import ctx_pkg::*;
    localparam int W = 120;
    localparam int NPE = 16;
    localparam int DEP = 16;
    localparam int AWD = 4;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    context_loader_if #(.WIDTH(W), .NUM_PE(NPE), .AW(AWD)) bus ();
    context_loader #(.WIDTH(W), .NUM_PE(NPE), .DEPTH(DEP), .AW(AWD)) dut (
        .CLK(clk),
        .RST_N(rst_n),
        .bus(bus)
    );
    typedef struct packed {
        logic [NPE-1:0] sel;
        logic [AWD-1:0] addr;
        logic [W:0] data;
    } wr_t;
    wr_t obs_q[$];
    wr_t exp_q[$];
    int errors = 0, checks = 0;
    int cyc = 0, hs_cyc = -1, wr_cyc = -1, start_cyc = -1, starts = 0, exp_starts = 0;
    logic exp_err = 1'b0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        if (bus.in_valid && bus.in_ready) hs_cyc = cyc;
    end

    always @(negedge clk) begin
        if (bus.wr_en) begin
            obs_q.push_back('{bus.pe_sel, bus.ctx_addr, bus.ctx_data});
            wr_cyc = cyc;
            chk("wr_after_last_beat", cyc, hs_cyc);
        end else chk("pe_sel_idle", bus.pe_sel, 0);
        if (bus.start) begin
            starts++;
            start_cyc = cyc;
        end
    end

    task automatic push(input logic [31:0] w, input int gap);
        int t = 0;
        bus.in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        bus.in_data = w;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("push_ready", bus.in_ready, 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Reference: a frame expands to one write per context unless its PE or slot range is out of bounds.
    task automatic frame(input logic [31:0] h, input int gap_max);
        int pe, base, cnt;
        bit bad;
        logic [127:0] acc;
        logic [31:0] w;
        pe = int'(h[7:0]);
        base = int'(h[15:8]);
        cnt = int'(h[23:16]);
        bad = pe >= NPE || base + cnt > DEP;
        push(h, int'($urandom_range(0, gap_max)));
        for (int c = 0; c < cnt; c++) begin
            acc = '0;
            for (int k = 0; k < BEATS; k++) begin
                w = $urandom;
                acc[32*k +: 32] = w;
                push(w, int'($urandom_range(0, gap_max)));
            end
            if (!bad) exp_q.push_back('{NPE'(1) << pe, AWD'(base + c), acc[W:0]});
        end
        if (h[31]) exp_starts++;
        exp_err |= bad;
        repeat (4) @(negedge clk);
    endtask

    task automatic settle(input string tag);
        chk({tag, "_nwr"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            chk({tag, "_sel"}, obs_q[i].sel, exp_q[i].sel);
            chk({tag, "_addr"}, obs_q[i].addr, exp_q[i].addr);
            chk({tag, "_data"}, obs_q[i].data, exp_q[i].data);
        end
        chk({tag, "_starts"}, starts, exp_starts);
        chk({tag, "_err"}, bus.err, exp_err);
        chk({tag, "_busy"}, bus.busy, 0);
        obs_q.delete();
        exp_q.delete();
        starts = 0;
        exp_starts = 0;
    endtask

    task automatic rst_outputs(input string tag);
        chk({tag, "_in_ready"}, bus.in_ready, 0);
        chk({tag, "_wr_en"}, bus.wr_en, 0);
        chk({tag, "_pe_sel"}, bus.pe_sel, 0);
        chk({tag, "_addr"}, bus.ctx_addr, 0);
        chk({tag, "_data"}, bus.ctx_data, 0);
        chk({tag, "_start"}, bus.start, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_err"}, bus.err, 0);
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        #1 rst_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready_after", bus.in_ready, 1);
        exp_err = 1'b0;
        obs_q.delete();
        exp_q.delete();
        starts = 0;
        exp_starts = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] h;
        int base, cnt, pe;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        repeat (2) @(negedge clk);
        reset_pulse();
        frame(32'h8003_0205, 0);
        chk("t1_start_after_wr", start_cyc, wr_cyc + 1);
        settle("t1");
        frame(32'h8000_0000, 0);
        chk("t2_start_after_hdr", start_cyc, hs_cyc);
        settle("t2");
        frame(32'h0001_0020, 1);
        settle("t3");
        reset_pulse();
        frame(32'h0002_0F00, 1);
        settle("t4");
        reset_pulse();
        for (int f = 0; f < 24; f++) begin
            pe = int'($urandom_range(0, (f % 6 == 5) ? 40 : NPE - 1));
            base = int'($urandom_range(0, DEP - 1));
            cnt = int'($urandom_range(0, (f % 4 == 3) ? DEP + 1 - base : DEP - base));
            h = {1'($urandom), 7'($urandom), 8'(cnt), 8'(base), 8'(pe)};
            frame(h, (f % 2) ? 3 : 0);
            settle("rnd");
        end
        push(32'h8001_0003, 0);
        push($urandom, 0);
        push($urandom, 1);
        rst_n = 1'b0;
        #1 rst_outputs("midrst");
        chk("midrst_no_wr", obs_q.size(), 0);
        chk("midrst_no_start", starts, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        exp_err = 1'b0;
        frame(32'h8001_0507, 0);
        settle("post_rst");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/context_loader.md
# context_loader

Streams configuration from the host into the PE context caches ahead of execution. It accepts a 32-bit valid/ready word stream, decodes a per-frame header, and assembles consecutive beats into WIDTH+1-bit context words. Each word is written into one slot of one PE's context cache. Once a frame flagged "go" completes, it issues the single-cycle `start` pulse that launches every PE's context pointer.

## Interface
- `WIDTH`, default 120: context word is WIDTH+1 bits, matching the PE `data` input.
- `NUM_PE`, default 16: number of PEs addressed, which is the `pe_sel` width.
- `DEPTH`, default 16: context slots per PE.
- `AW`, default 4: slot address width, equal to log2(DEPTH).

Ports:
- `CLK` in 1: single clock; all state changes on the rising edge.
- `RST_N` in 1: reset, asynchronous assert, active-low.
- `in_data` in 32: host word.
- `in_valid` in 1: host word valid.
- `in_ready` out 1: loader accepts the word this cycle.
- `ctx_data` out WIDTH+1: assembled context word.
- `ctx_addr` out AW: destination slot.
- `pe_sel` out NUM_PE: one-hot PE write enable, non-zero only while `wr_en` is high.
- `wr_en` out 1: context write strobe.
- `start` out 1: one-cycle launch pulse to all PEs.
- `busy` out 1: high in any state other than IDLE.
- `err` out 1: sticky frame error, cleared only by reset.

## Operation
- A handshake occurs when `in_valid` and `in_ready` are both high in the same cycle; only accepted words are consumed.
- Header word fields:
  - [7:0] PE index.
  - [15:8] base slot.
  - [23:16] count of contexts.
  - [31] go.
  - Bits [30:24] are ignored.
- BEATS = ceil((WIDTH+1)/32), which is 4 at the default WIDTH. Beat k fills bits [32k+31:32k]; bits above WIDTH in the last beat are discarded.
- Frame checks:
  - PE index >= NUM_PE, or base+count > DEPTH, flags the frame bad.
  - A bad frame sets `err`.
  - Its payload (count×BEATS words) is still consumed, but no writes are issued.
  - `start` is still pulsed if go=1.
- States:
  - IDLE: `in_ready`=1. A header handshake latches the fields, then:
    - count>0 goes to RECV;
    - count=0 with go=1 goes to LAUNCH;
    - count=0 with go=0 stays in IDLE.
  - RECV: `in_ready`=1. Each handshake stores one beat. After beat BEATS-1, go to WRITE.
  - WRITE: `in_ready`=0. For a good frame, drive `wr_en`=1, `pe_sel`=1<<PE, `ctx_addr`=base+i, and `ctx_data`. Then increment i:
    - if i+1<count, go to RECV;
    - else if go=1, go to LAUNCH;
    - else go to IDLE.
  - LAUNCH: `in_ready`=0, `start`=1 for exactly one cycle, then IDLE.
- `ctx_addr` is computed as base+i truncated to AW bits. The frame check guarantees no wrap for good frames.
- `in_valid` low mid-frame: the loader holds state indefinitely with no timeout.

## Timing
- Reset values (async on `RST_N` low): state IDLE, `in_ready`=0 while in reset, `wr_en`=0, `pe_sel`=0, `ctx_addr`=0, `ctx_data`=0, `start`=0, `busy`=0, `err`=0.
- `in_ready`=1 from the first edge after `RST_N` deasserts.
- All outputs are registered.
- Continuous valid, default WIDTH:
  - header accepted at cycle 0;
  - beats accepted at cycles 1–4;
  - `wr_en` high at cycle 5;
  - next context's beats at cycles 6–9.
- Steady-state throughput is 1 context per BEATS+1 cycles.
- `start` is asserted the cycle after the last WRITE cycle.
- `ctx_data`, `ctx_addr`, and `pe_sel` are valid only when `wr_en`=1. Otherwise `pe_sel`=0 and the other two hold their last value.
- Reset mid-frame: the partial context is discarded, no write or `start` is emitted, and the loader returns to IDLE.

## Structure
- Package `ctx_pkg` holds:
  - the state enum (IDLE, RECV, WRITE, LAUNCH);
  - the BEATS constant;
  - header field bit positions.
- Sub-module `ctx_assembler`: beat counter plus WIDTH+1-bit assembly register.
  - Inputs: `CLK`, `RST_N`, beat strobe, clear.
  - Outputs: assembled word and a last-beat flag.

## Test plan
- Header 0x8003_0205 then 12 words → exactly 3 writes:
  - `pe_sel`=0x0020, `ctx_addr` 2, 3, 4;
  - `ctx_data` matches the beats with bits 127:121 dropped;
  - one `start` the cycle after the third write.
- Header 0x8000_0000 → `start` pulses 1 cycle after the header; no `wr_en`.
- Header with PE index 0x20 and count 1 → 4 payload words consumed, no `wr_en`, `err`=1, no `start` since go=0.
- Header with base 15, count 2 → `err`=1, no writes.
- Random `in_valid` gaps → data identical to the back-to-back case; `wr_en` count equals header count.
- `RST_N` pulled low after beat 2 of a context → outputs reset immediately. A new frame after release writes correctly with no residue from the old beats.
